// File: rtl/jpeg_pkg.sv
// jpeg_pkg: shared tables, widths and state encoding for the JPEG dequantizer
package jpeg_pkg;
    localparam int BLK  = 64;
    localparam int ZZ_W = 6;
    localparam int SH_W = 3;

    typedef enum logic {FILL, DRAIN} state_t;

    // Power-of-two quantization table, raster order, entries are left-shift amounts
    localparam logic [SH_W-1:0] QSHIFT [BLK] = '{
        4, 3, 3, 4, 5, 5, 6, 6,
        3, 3, 4, 4, 5, 6, 6, 6,
        4, 4, 4, 5, 5, 6, 6, 6,
        4, 4, 4, 5, 6, 6, 6, 6,
        4, 4, 5, 6, 6, 7, 7, 6,
        4, 5, 6, 6, 6, 7, 7, 6,
        5, 6, 6, 7, 7, 7, 7, 7,
        6, 7, 7, 7, 7, 7, 7, 7
    };

    // Zigzag scan position -> raster index
    localparam logic [ZZ_W-1:0] ZIGZAG [BLK] = '{
         0,  1,  8, 16,  9,  2,  3, 10,
        17, 24, 32, 25, 18, 11,  4,  5,
        12, 19, 26, 33, 40, 48, 41, 34,
        27, 20, 13,  6,  7, 14, 21, 28,
        35, 42, 49, 56, 57, 50, 43, 36,
        29, 22, 15, 23, 30, 37, 44, 51,
        58, 59, 52, 45, 38, 31, 39, 46,
        53, 60, 61, 54, 47, 55, 62, 63
    };
endpackage

// File: rtl/jpeg_zigzag_rom.sv
// jpeg_zigzag_rom: zigzag position -> raster index and quantization shift lookup
module jpeg_zigzag_rom import jpeg_pkg::*; (
    input  logic [ZZ_W-1:0] i_zz,
    output logic [ZZ_W-1:0] o_raster,
    output logic [SH_W-1:0] o_shift
);
    assign o_raster = ZIGZAG[i_zz];
    assign o_shift  = QSHIFT[o_raster];
endmodule

// File: rtl/jpeg_dequant.sv
// jpeg_dequant: zigzag-in dequantizer with an 8x8 block buffer drained in raster order
module jpeg_dequant import jpeg_pkg::*; #(
    parameter int WN = 7,
    parameter int W  = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [WN:0]   in_data,
    input  logic          in_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W:0]    out_data,
    output logic [5:0]    out_idx,
    output logic          out_last
);
    state_t            r_state, w_next;
    logic [ZZ_W-1:0]   r_zz_cnt, r_out_idx, w_raster;
    logic [SH_W-1:0]   w_shift;
    logic [BLK-1:0]    r_mask;
    logic [W:0]        r_buf [BLK];
    logic [W:0]        w_ext;
    logic              w_in_fire, w_out_fire, w_fill_done;

    jpeg_zigzag_rom u_rom (.i_zz(r_zz_cnt), .o_raster(w_raster), .o_shift(w_shift));

    assign in_ready    = r_state == FILL;
    assign out_valid   = r_state == DRAIN;
    assign w_in_fire   = in_valid && in_ready;
    assign w_out_fire  = out_valid && out_ready;
    assign w_fill_done = w_in_fire && (in_last || r_zz_cnt == 6'd63);
    assign w_ext       = {{(W-WN){in_data[WN]}}, in_data};
    assign out_idx     = r_out_idx;
    assign out_last    = out_valid && r_out_idx == 6'd63;
    // The mask hides anything left in the buffer from earlier blocks
    assign out_data    = (out_valid && r_mask[r_out_idx]) ? r_buf[r_out_idx] : '0;

    always_comb begin
        w_next = (r_state == FILL) ? (w_fill_done ? DRAIN : FILL) : ((w_out_fire && out_last) ? FILL : DRAIN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= FILL;
        else     r_state <= w_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_zz_cnt  <= '0;
            r_out_idx <= '0;
            r_mask    <= '0;
        end else begin
            if (w_in_fire) begin
                r_zz_cnt         <= w_fill_done ? '0 : r_zz_cnt + 6'd1;
                r_mask[w_raster] <= 1'b1;
            end
            if (w_out_fire) begin
                r_out_idx <= r_out_idx + 6'd1;
                if (out_last) r_mask <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_in_fire) r_buf[w_raster] <= w_ext << w_shift;
    end
endmodule

// File: tb/tb_jpeg_dequant.sv
// tb_jpeg_dequant: directed vector table plus hand sequences for jpeg_dequant
module tb_jpeg_dequant;
    logic        clk = 0, rst = 1, in_valid = 0, in_last = 0, out_ready = 0;
    logic [7:0]  in_data = 0;
    logic        in_ready, out_valid, out_last;
    logic [15:0] out_data;
    logic [5:0]  out_idx;

    jpeg_dequant #(.WN(7), .W(15)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_idx(out_idx), .out_last(out_last)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         k;
        logic [7:0] q;
        bit         use_last;
        int         p;
        logic [15:0] e;
    } vec_t;

    int          tests = 0, fails = 0;
    logic [7:0]  bq   [64];
    logic [15:0] bexp [64];
    logic [15:0] got  [64];
    int          zzm  [64];
    int          qsh  [64];
    vec_t        vt   [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic send_block(input int n, input bit use_last, input int gap_pct, input bit finish);
        for (int k = 0; k < n; k++) begin
            while ($urandom_range(99) < gap_pct) begin
                in_valid = 0;
                in_data  = 8'($urandom);
                @(negedge clk);
            end
            in_valid = 1;
            in_data  = bq[k];
            in_last  = use_last && (k == n - 1);
            begin
                int t = 0;
                while (!in_ready && t < 100) begin
                    @(negedge clk);
                    t++;
                end
                if (!in_ready) check("in_ready timeout", 0, 1);
            end
            @(negedge clk);
            if (k < n - 1) check("no early out_valid", out_valid, 0);
        end
        in_valid = 0;
        in_last  = 1;
        in_data  = 8'($urandom);
        if (finish) check("out_valid latency", out_valid, 1);
    endtask

    task automatic drain(input int stall_pct);
        int cnt = 0, cyc = 0;
        bit pstall = 0;
        logic [15:0] pd = 0;
        logic [5:0]  pi = 0;
        while (cnt < 64 && cyc < 3000) begin
            out_ready = ($urandom_range(99) >= stall_pct);
            if (pstall) begin
                check("hold out_data", out_data, pd);
                check("hold out_idx", out_idx, pi);
            end
            pstall = 0;
            if (out_valid) begin
                check("in_ready low in drain", in_ready, 0);
                if (out_ready) begin
                    check("out_idx order", out_idx, cnt);
                    check("out_last", out_last, cnt == 63);
                    got[cnt] = out_data;
                    cnt++;
                end else begin
                    pstall = 1;
                    pd = out_data;
                    pi = out_idx;
                end
            end
            @(negedge clk);
            cyc++;
        end
        out_ready = 0;
        check("drain count", cnt, 64);
        check("back to FILL", in_ready, 1);
        check("out_valid off", out_valid, 0);
        for (int i = 0; i < 64; i++) check($sformatf("data[%0d]", i), got[i], bexp[i]);
    endtask

    task automatic model_block(input int n);
        for (int i = 0; i < 64; i++) bexp[i] = 16'h0;
        for (int k = 0; k < n; k++) begin
            int v;
            v = $signed(bq[k]);
            v = v * (1 << qsh[zzm[k]]);
            bexp[zzm[k]] = v[15:0];
        end
    endtask

    task automatic random_block(input int gap_pct, input int stall_pct);
        for (int k = 0; k < 64; k++) bq[k] = 8'($urandom);
        model_block(64);
        send_block(64, 1'($urandom_range(1)), gap_pct, 1);
        drain(stall_pct);
    endtask

    initial begin
        begin
            int r = 0, c = 0;
            for (int k = 0; k < 64; k++) begin
                zzm[k] = r * 8 + c;
                if ((r + c) % 2 == 0) begin
                    if (c == 7) r++;
                    else if (r == 0) c++;
                    else begin r--; c++; end
                end else begin
                    if (r == 7) c++;
                    else if (c == 0) r++;
                    else begin r++; c--; end
                end
            end
        end
        qsh = '{4,3,3,4,5,5,6,6, 3,3,4,4,5,6,6,6, 4,4,4,5,5,6,6,6, 4,4,4,5,6,6,6,6,
                4,4,5,6,6,7,7,6, 4,5,6,6,6,7,7,6, 5,6,6,7,7,7,7,7, 6,7,7,7,7,7,7,7};
        vt[0]  = '{0,  8'h05, 1'b1, 0,  16'h0050};
        vt[1]  = '{1,  8'hFF, 1'b1, 1,  16'hFFF8};
        vt[2]  = '{2,  8'h02, 1'b1, 8,  16'h0010};
        vt[3]  = '{63, 8'h7F, 1'b0, 63, 16'h3F80};
        vt[4]  = '{63, 8'h80, 1'b1, 63, 16'hC000};
        vt[5]  = '{5,  8'h01, 1'b1, 2,  16'h0008};
        vt[6]  = '{9,  8'h10, 1'b1, 24, 16'h0100};
        vt[7]  = '{35, 8'hFE, 1'b1, 56, 16'hFF80};
        vt[8]  = '{28, 8'h81, 1'b1, 7,  16'hE040};
        vt[9]  = '{42, 8'h40, 1'b1, 15, 16'h1000};
        vt[10] = '{48, 8'h03, 1'b1, 58, 16'h0180};
        vt[11] = '{20, 8'h7F, 1'b1, 40, 16'h07F0};

        repeat (2) @(negedge clk);
        check("reset in_ready", in_ready, 1);
        check("reset out_valid", out_valid, 0);
        check("reset out_last", out_last, 0);
        check("reset out_data", out_data, 0);
        check("reset out_idx", out_idx, 0);
        rst = 0;
        @(negedge clk);

        for (int v = 0; v < 12; v++) begin
            for (int i = 0; i < 64; i++) begin
                bq[i]   = 8'h00;
                bexp[i] = 16'h0;
            end
            bq[vt[v].k]   = vt[v].q;
            bexp[vt[v].p] = vt[v].e;
            send_block(vt[v].k + 1, vt[v].use_last, 0, 1);
            drain(0);
        end

        for (int i = 0; i < 64; i++) begin
            bq[i]   = 8'h00;
            bexp[i] = 16'h0;
        end
        bq[1] = 8'hFF; bq[2] = 8'h02;
        bexp[1] = 16'hFFF8; bexp[8] = 16'h0010;
        send_block(3, 1, 0, 1);
        drain(0);

        for (int k = 0; k < 64; k++) bq[k] = 8'($urandom);
        bq[63] = 8'h7F;
        model_block(64);
        check("model idx63 blk1", bexp[63], 16'h3F80);
        send_block(64, 0, 0, 1);
        drain(0);
        for (int k = 0; k < 64; k++) bq[k] = 8'($urandom);
        bq[63] = 8'h80;
        model_block(64);
        send_block(64, 1, 0, 1);
        drain(40);

        for (int k = 0; k < 64; k++) bq[k] = 8'($urandom_range(255, 1));
        send_block(64, 0, 0, 1);
        out_ready = 1;
        begin
            int t = 0;
            while (out_idx != 6'd20 && t < 200) begin
                @(negedge clk);
                t++;
            end
        end
        check("reached idx 20", out_idx, 20);
        out_ready = 0;
        #2 rst = 1;
        #1;
        check("async rst in_ready", in_ready, 1);
        check("async rst out_valid", out_valid, 0);
        check("async rst out_data", out_data, 0);
        check("async rst out_idx", out_idx, 0);
        check("async rst out_last", out_last, 0);
        @(negedge clk);
        rst = 0;
        @(negedge clk);

        for (int i = 0; i < 64; i++) begin
            bq[i]   = 8'h00;
            bexp[i] = 16'h0;
        end
        bq[0] = 8'h05;
        bexp[0] = 16'h0050;
        send_block(1, 1, 0, 1);
        drain(0);

        for (int k = 0; k < 64; k++) bq[k] = 8'($urandom_range(255, 1));
        send_block(10, 0, 0, 0);
        #2 rst = 1;
        #1 check("fill rst in_ready", in_ready, 1);
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        for (int i = 0; i < 64; i++) begin
            bq[i]   = 8'h00;
            bexp[i] = 16'h0;
        end
        bq[1] = 8'h7F;
        bexp[1] = 16'h03F8;
        send_block(2, 1, 0, 1);
        drain(0);

        for (int b = 0; b < 4; b++) random_block(30, 30);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/jpeg_dequant.md
# jpeg_dequant

Streaming JPEG dequantizer for the decode path. Accepts one quantized coefficient per handshake in zigzag order, rescales it by the fixed power-of-two quantization table as an arithmetic left shift, and de-zigzags it into an 8x8 block buffer. Once the block is complete it drains the 64 dequantized coefficients in raster order toward the IDCT. It is the inverse of the encoder-side quantization stage.

## Interface
- `WN`, default 7: MSB index of the quantized input coefficient (8-bit signed).
- `W`, default 15: MSB index of the dequantized output coefficient (16-bit signed). Must satisfy W >= WN+7.
- `clk` input, 1: clock. Rising-edge sensitive.
- `rst` input, 1: reset. **Asynchronous, active-high.**
- `in_valid` input, 1: `in_data` is valid.
- `in_ready` output, 1: block accepts input. High only in FILL.
- `in_data` input, WN+1: signed quantized coefficient, zigzag order.
- `in_last` input, 1: end of block. Every remaining coefficient of the block is zero.
- `out_valid` output, 1: `out_data` is valid.
- `out_ready` input, 1: downstream accepts.
- `out_data` output, W+1: signed dequantized coefficient, raster order.
- `out_idx` output, 6: raster index (row*8+col) of `out_data`.
- `out_last` output, 1: high with `out_idx`==63 while `out_valid`.

## Operation
- Two states, FILL and DRAIN. Reset enters FILL.
- **FILL:**
  - `in_ready`=1.
  - On each `in_valid`&&`in_ready`:
    - p = ZIGZAG[zz_cnt].
    - buf[p] = sign_extend(`in_data`) <<< QSHIFT[p], computed at width W+1 with no saturation.
    - mask[p] = 1.
    - zz_cnt increments.
  - Transition to DRAIN when the accepted beat has `in_last`=1 or zz_cnt==63. zz_cnt then clears to 0.
- **DRAIN:**
  - `out_valid`=1, `in_ready`=0.
  - `out_data` = mask[out_idx] ? buf[out_idx] : 0.
  - On `out_valid`&&`out_ready`, `out_idx` increments.
  - On the handshake at `out_idx`==63: `out_idx` wraps to 0, mask clears to all-zero, state returns to FILL.
- QSHIFT in raster rows, rows 0..7, columns 0..7:
  - row 0: 4 3 3 4 5 5 6 6
  - row 1: 3 3 4 4 5 6 6 6
  - row 2: 4 4 4 5 5 6 6 6
  - row 3: 4 4 4 5 6 6 6 6
  - row 4: 4 4 5 6 6 7 7 6
  - row 5: 4 5 6 6 6 7 7 6
  - row 6: 5 6 6 7 7 7 7 7
  - row 7: 6 7 7 7 7 7 7 7
- ZIGZAG is the standard JPEG zigzag-to-raster map: 0,1,8,16,9,2,3,10,17,24,… ending …,47,55,62,63.
- Coefficients not written in the current block read as 0 through mask. Stale buf contents never appear on `out_data`.

## Timing
- Reset values:
  - state FILL, zz_cnt 0, `out_idx` 0, mask 0.
  - `in_ready`=1, `out_valid`=0, `out_last`=0, `out_data`=0.
- Latency: `out_valid` rises the cycle after the handshake that completes FILL.
  - Full block: 64 input beats, then 64 output beats, so 128 cycles minimum per block.
  - Early `in_last` at beat k: k+1 input beats, then 64 output beats.
- `out_data`, `out_idx` and `out_last` hold stable while `out_valid`&&!`out_ready`.
- `in_data` and `in_last` are ignored when `in_valid`=0 or in DRAIN. No input and output overlap occurs.
- `in_last` on beat 64 and the zz_cnt==63 terminal count produce the same single transition.
- Reset asserted mid-FILL or mid-DRAIN aborts the block immediately. No partial output follows; the next block starts at zz_cnt 0.

## Structure
- `jpeg_pkg` holds:
  - the QSHIFT[64] constant table (3-bit entries),
  - the ZIGZAG[64] constant table (6-bit entries),
  - the state enum {FILL, DRAIN},
  - width constants.
- Sub-module `jpeg_zigzag_rom` is a combinational zz index → raster index and shift lookup built from the package tables. It is reusable by a future encoder-side zigzag scanner.
- buf is 64×(W+1) flops. mask is a 64-bit register.

## Test plan
- Zigzag 0 = 8'h05, then 63 zeros → raster 0 = 16'h0050, all other outputs 0, `out_last` at idx 63 only.
- Beats zz0=0, zz1=8'hFF, zz2=8'h02, then `in_last` → idx1 = 16'hFFF8, idx8 = 16'h0010, remaining 61 outputs 0. `out_valid` rises 1 cycle after the 3rd beat.
- Full block with zz63 = 8'h7F, then a second full block with zz63 = 8'h80 → idx63 = 16'h3F80, then 16'hC000. No data from block 1 leaks into block 2.
- Random `out_ready` stalls → `out_data`/`out_idx` held during stalls. Exactly 64 accepted outputs; `in_ready`=0 throughout DRAIN.
- `rst` pulsed at output idx 20 → all outputs return to reset values asynchronously. The next block outputs correct values from idx 0, with mask-zero elsewhere.
- Random 64-coefficient blocks with random `in_valid` gaps, compared against a model of sign_extend(q)<<QSHIFT[ZIGZAG[k]] → bit-exact match.
